// File: rtl/keyboard_ascii_source_if.sv
// Bundles the PS/2 input lines and the decoded-character outputs.
// The decoder uses the master modport; the keyboard/consumer side uses slave.
interface keyboard_ascii_source_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ascii;
    logic       write_enable;
    logic       frame_error;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output ascii,
        output write_enable,
        output frame_error
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  ascii,
        input  write_enable,
        input  frame_error
    );
endinterface

// File: rtl/keyboard_ascii_source.sv
// PS/2 keyboard receiver: synchronize, deglitch ps2_clk, deframe 11-bit frames,
// then decode Set 2 scan codes (shift/break/extended) into ASCII write strobes.
module keyboard_ascii_source #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                           clk,
    input  logic                           rst,
    keyboard_ascii_source_if.master        bus
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_s, data_s;
    logic          clk_filt, filt_flip, fall;
    logic [FW-1:0] filt_cnt;

    // NOTE: synchronizers reset to 1 so an idle (high) bus never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    assign clk_s     = clk_sync[1];
    assign data_s    = data_sync[1];
    assign filt_flip = (clk_s != clk_filt) && (filt_cnt == FW'(FILT_LEN - 1));
    assign fall      = filt_flip && clk_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit, byte_stb_d, err_d;

    assign timeout_hit = (state_q != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_ok_d   = par_ok_q;
        byte_stb_d = 1'b0;
        err_d      = 1'b0;
        if (timeout_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                IDLE: if (!data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
                DATA: begin
                    shreg_d   = {data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shreg_q, data_s};
                    state_d  = STOP;
                end
                STOP: begin
                    if (data_s && par_ok_q) byte_stb_d = 1'b1;
                    else                    err_d      = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic       byte_stb_q;
    logic [7:0] byte_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            shreg_q         <= '0;
            par_ok_q        <= 1'b0;
            tmo_cnt         <= '0;
            byte_stb_q      <= 1'b0;
            byte_q          <= '0;
            bus.frame_error <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shreg_q         <= shreg_d;
            par_ok_q        <= par_ok_d;
            tmo_cnt         <= (state_q == IDLE || fall) ? '0 : tmo_cnt + TW'(1);
            byte_stb_q      <= byte_stb_d;
            if (byte_stb_d) byte_q <= shreg_q;
            bus.frame_error <= err_d;
        end
    end

    // Returns {mapped, ascii} for a Set 2 make code (lowercase letters).
    function automatic logic [8:0] map_code(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        unique case (code)
            8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
            8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
            8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
            8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
            8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
            8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
            8'h35: a = "y";  8'h1A: a = "z";
            8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
            8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
            8'h3E: a = "8";  8'h46: a = "9";
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return {a != 8'h00, a};
    endfunction

    logic       shift_f, break_f, ext_f;
    logic [8:0] mapped;
    logic       is_shift, is_letter;

    assign mapped    = map_code(byte_q);
    assign is_shift  = (byte_q == 8'h12) || (byte_q == 8'h59);
    assign is_letter = (mapped[7:0] >= 8'h61) && (mapped[7:0] <= 8'h7A);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_f          <= 1'b0;
            break_f          <= 1'b0;
            ext_f            <= 1'b0;
            bus.ascii        <= 8'h00;
            bus.write_enable <= 1'b0;
        end else begin
            bus.write_enable <= 1'b0;
            if (byte_stb_q) begin
                if (byte_q == 8'hF0) begin
                    break_f <= 1'b1;
                end else if (byte_q == 8'hE0) begin
                    ext_f <= 1'b1;
                end else if (ext_f) begin
                    ext_f   <= 1'b0;
                    break_f <= 1'b0;
                end else if (break_f) begin
                    if (is_shift) shift_f <= 1'b0;
                    break_f <= 1'b0;
                end else if (is_shift) begin
                    shift_f <= 1'b1;
                end else if (mapped[8]) begin
                    bus.ascii        <= (shift_f && is_letter) ? mapped[7:0] - 8'h20 : mapped[7:0];
                    bus.write_enable <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/keyboard_ascii_source.md
KEYBOARD_ASCII_SOURCE -- requirements
Module: keyboard_ascii_source

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8: number of consecutive equal samples required to accept a new ps2_clk level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000: number of clk cycles without a falling edge after which a partial frame is aborted.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic in this single domain.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: keyboard data, asynchronous to clk.
REQ-007 SHALL have port ascii, output, 8 bits: last decoded character, held until the next write.
REQ-008 SHALL have port write_enable, output, 1 bit: one-cycle strobe marking a new ascii value, feeding the display's write_enable/ascii inputs.
REQ-009 SHALL have port frame_error, output, 1 bit: one-cycle strobe on a parity, stop or timeout error.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer.
REQ-011 SHALL change the filtered ps2_clk level only after FILT_LEN consecutive identical synchronized samples; a falling edge is a filtered 1->0 transition.
REQ-012 SHALL use frame FSM states IDLE, DATA, PARITY, STOP, sampling synchronized ps2_data only in the cycle of a falling edge.
REQ-013 IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay in IDLE with no error.
REQ-014 DATA: SHALL shift in 8 bits LSB first, then go to PARITY after the 8th bit.
REQ-015 PARITY: SHALL check odd parity over data+parity bit, then go to STOP.
REQ-016 STOP: sampled 1 with correct parity -> deliver the byte to the decoder; any failure -> pulse frame_error and discard the byte; both cases return to IDLE.
REQ-017 Outside IDLE, TIMEOUT_CYC cycles without a falling edge SHALL force IDLE and pulse frame_error; the timeout counter clears on every falling edge.
REQ-018 Decoder: byte 0xF0 SHALL set the break flag; byte 0xE0 SHALL set the extended flag; neither produces output.
REQ-019 The byte following F0 is a release: 0x12/0x59 clears shift; otherwise no action; the break flag then clears.
REQ-020 The byte following E0, with or without F0, SHALL be discarded and both flags cleared.
REQ-021 Make codes 0x12/0x59 SHALL set shift and produce no output.
REQ-022 Other make codes SHALL map to PS/2 Set 2 ASCII: a-z lowercase (e.g. 0x1C->0x61), 0-9 (0x45->0x30, 0x16->0x31), 0x29->0x20, 0x5A->0x0D, 0x66->0x08.
REQ-023 With shift set, letters SHALL map to uppercase (code-0x20); digits and controls are unaffected.
REQ-024 Unmapped make codes SHALL produce no output and no error.
REQ-025 For a mapped make code, ascii SHALL update and write_enable SHALL pulse high for exactly one cycle, 2 clk cycles after the stop-bit falling-edge cycle.
REQ-026 Typematic repeats (the same make code again without a break) SHALL each produce a new write.
REQ-027 ascii SHALL not change except in a write_enable cycle.

Reset
REQ-028 On rst high: ascii=0x00, write_enable=0, frame_error=0, FSM=IDLE, shift/break/extended flags=0, counters=0, filtered clk=1, synchronizers=1; this takes effect immediately, including mid-frame.
REQ-029 After rst release, the first frame SHALL be accepted only from a valid start bit; a partial frame is never resumed.

Verification
REQ-030 Frame 0x1C with good parity/stop -> write_enable one pulse, ascii=0x61, 2 cycles after the stop edge.
REQ-031 Frames 0x12, 0x1C, F0 0x1C, F0 0x12, 0x1C -> writes 0x41 then 0x61; no writes for shift, break or release frames.
REQ-032 Frame 0x1C with a wrong parity bit -> frame_error one pulse, no write, ascii unchanged.
REQ-033 Five bits then idle for TIMEOUT_CYC cycles -> frame_error pulse, FSM IDLE; next good 0x45 frame -> ascii=0x30.
REQ-034 E0 0x75, then E0 F0 0x75 -> no writes, flags clear; a following 0x29 -> ascii=0x20.
REQ-035 rst asserted mid-frame -> all outputs 0 immediately; after release a clean 0x5A frame -> ascii=0x0D; glitches shorter than FILT_LEN on ps2_clk -> no bit sampled.
